// File: rtl/inbyte1200_if.sv
// Caller-side bundle for the 1200 bps 8N1 byte receiver: request, serial line, returned byte and sticky flags.
interface inbyte1200_if;
    logic       start;
    logic       inchan;
    logic [7:0] result;
    logic       result_ready;
    logic       overrun;
    logic       framing_error;

    modport master (
        output start, inchan,
        input  result, result_ready, overrun, framing_error
    );

    modport slave (
        input  start, inchan,
        output result, result_ready, overrun, framing_error
    );
endinterface

// File: rtl/inbyte1200.sv
// Receive side of the 1200 bps 8N1 link: oversampled deserialiser, one-byte holding register,
// and a start/result/result_ready handshake that hands the held byte to the caller.
module inbyte1200 #(
    parameter int CLK_DIV    = 2604,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         wb_rst_i,
    inbyte1200_if.slave  bus
);
    localparam logic [1:0] ST_READY      = 2'b00;
    localparam logic [1:0] ST_WAITING    = 2'b01;
    localparam logic [1:0] ST_NEVERNEVER = 2'b11;

    localparam logic [2:0] RX_LINEWAIT = 3'd0;
    localparam logic [2:0] RX_IDLE     = 3'd1;
    localparam logic [2:0] RX_START    = 3'd2;
    localparam logic [2:0] RX_DATA     = 3'd3;
    localparam logic [2:0] RX_STOP     = 3'd4;

    localparam logic [11:0] DIV_RELOAD = 12'(CLK_DIV - 1);
    localparam logic [3:0]  SCNT_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  SCNT_LAST  = 4'(OVERSAMPLE - 1);

    logic [1:0]  r_sync;
    logic [11:0] r_div;
    logic [2:0]  r_rx_state;
    logic [3:0]  r_scnt;
    logic [2:0]  r_bidx;
    logic [7:0]  r_sreg;
    logic        r_rx_done;
    logic [7:0]  r_rx_byte;
    logic        r_framing_error;
    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic        r_overrun;
    logic [1:0]  r_top_state;
    logic [7:0]  r_result;

    logic w_rx_s;
    logic w_tick;
    logic w_consume;

    // Synchroniser clears low so a reset during a low line keeps the receiver in RX_LINEWAIT.
    // NOTE: every clocked register uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (wb_rst_i) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], bus.inchan};
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (wb_rst_i)           r_div <= DIV_RELOAD;
        else if (r_div == 12'd0) r_div <= DIV_RELOAD;
        else                    r_div <= r_div - 12'd1;
    end

    assign w_tick = (r_div == 12'd0);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_rx_state      <= RX_LINEWAIT;
            r_scnt          <= 4'd0;
            r_bidx          <= 3'd0;
            r_sreg          <= 8'd0;
            r_rx_done       <= 1'b0;
            r_rx_byte       <= 8'd0;
            r_framing_error <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (bus.start) r_framing_error <= 1'b0;
            if (w_tick) begin
                case (r_rx_state)
                    RX_LINEWAIT: begin
                        if (w_rx_s) r_rx_state <= RX_IDLE;
                    end
                    RX_IDLE: begin
                        if (!w_rx_s) begin
                            r_rx_state <= RX_START;
                            r_scnt     <= 4'd0;
                        end
                    end
                    RX_START: begin
                        if (r_scnt == SCNT_MID) begin
                            r_scnt <= 4'd0;
                            r_bidx <= 3'd0;
                            r_rx_state <= w_rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            r_scnt <= r_scnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == SCNT_LAST) begin
                            r_sreg <= {w_rx_s, r_sreg[7:1]};
                            if (r_bidx == 3'd7) r_rx_state <= RX_STOP;
                            else                r_bidx     <= r_bidx + 3'd1;
                        end
                    end
                    RX_STOP: begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == SCNT_LAST) begin
                            if (w_rx_s) begin
                                r_rx_done  <= 1'b1;
                                r_rx_byte  <= r_sreg;
                                r_rx_state <= RX_IDLE;
                            end else begin
                                r_framing_error <= 1'b1;
                                r_rx_state      <= RX_LINEWAIT;
                            end
                        end
                    end
                    default: r_rx_state <= RX_LINEWAIT;
                endcase
            end
        end
    end

    // A pending start takes the FSM back to WAITING, so the hold is not consumed that cycle.
    assign w_consume = (r_top_state == ST_WAITING) && r_hold_valid && !bus.start;

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_hold       <= 8'd0;
            r_hold_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_top_state  <= ST_READY;
            r_result     <= 8'd0;
        end else begin
            if (bus.start) r_overrun <= 1'b0;

            if (r_rx_done) begin
                r_hold       <= r_rx_byte;
                r_hold_valid <= 1'b1;
                if (r_hold_valid && !w_consume) r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_hold_valid <= 1'b0;
            end

            if (bus.start) begin
                r_top_state <= ST_WAITING;
            end else begin
                case (r_top_state)
                    ST_READY: r_top_state <= ST_READY;
                    ST_WAITING: begin
                        if (r_hold_valid) begin
                            r_result    <= r_hold;
                            r_top_state <= ST_READY;
                        end
                    end
                    ST_NEVERNEVER: r_top_state <= ST_READY;
                    default:       r_top_state <= ST_READY;
                endcase
            end
        end
    end

    assign bus.result        = r_result;
    assign bus.result_ready  = (r_top_state == ST_READY) && !bus.start;
    assign bus.overrun       = r_overrun;
    assign bus.framing_error = r_framing_error;
endmodule

// File: tb/tb_inbyte1200.sv
// Directed bench for inbyte1200: expected bytes/flags are queued at each request and
// checked by a monitor on every rising edge of result_ready.
module tb_inbyte1200;
    localparam int CLK_DIV_TB = 4;
    localparam int OVS        = 16;
    localparam int BIT_CLK    = CLK_DIV_TB * OVS;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic prev_rr = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    inbyte1200_if bus ();

    inbyte1200 #(.CLK_DIV(CLK_DIV_TB), .OVERSAMPLE(OVS)) dut (
        .clk      (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic ovr, input logic fe);
        exp_t e;
        e.data = d;
        e.ovr  = ovr;
        e.fe   = fe;
        sb_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.inchan = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.inchan = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.inchan = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        bus.inchan = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int left;
        left = budget;
        while (sb_q.size() != 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d expected responses still outstanding after %0d cycles",
                     name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    // Monitor: every rising edge of result_ready outside reset is one response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && bus.result_ready && !prev_rr) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: response 0x%0h with nothing expected", bus.result);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result",  {24'd0, bus.result},        {24'd0, e.data});
                    check("sb_overrun", {31'd0, bus.overrun},       {31'd0, e.ovr});
                    check("sb_framing", {31'd0, bus.framing_error}, {31'd0, e.fe});
                end
            end
            prev_rr = bus.result_ready;
        end
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.inchan = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready",   {31'd0, bus.result_ready},  32'd1);
        check("rst_result",  {24'd0, bus.result},        32'd0);
        check("rst_overrun", {31'd0, bus.overrun},       32'd0);
        check("rst_framing", {31'd0, bus.framing_error}, 32'd0);
        repeat (2 * BIT_CLK) @(negedge clk);

        // 1: request first, then the byte arrives
        push(8'h41, 1'b0, 1'b0);
        do_start();
        send_frame(8'h41, 1'b1);
        wait_drain("t1_drain", 4 * BIT_CLK);

        // 2: byte already held; response exactly two cycles after start
        send_frame(8'hA5, 1'b1);
        repeat (100) @(negedge clk);
        push(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        check("t2_ready_n0", {31'd0, bus.result_ready}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("t2_ready_n1", {31'd0, bus.result_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("t2_ready_n2", {31'd0, bus.result_ready}, 32'd1);
        check("t2_result",   {24'd0, bus.result},       32'hA5);
        wait_drain("t2_drain", 10);

        // 3: two bytes with no request -> overrun, newest byte kept
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("t3_overrun_set", {31'd0, bus.overrun},       32'd1);
        check("t3_framing",     {31'd0, bus.framing_error}, 32'd0);
        push(8'h22, 1'b0, 1'b0);
        do_start();
        wait_drain("t3_drain", 20);
        #1;
        check("t3_overrun_clr", {31'd0, bus.overrun}, 32'd0);

        // 4: short low glitch is rejected; request stays outstanding
        bus.inchan = 1'b0;
        repeat (4 * CLK_DIV_TB) @(negedge clk);
        bus.inchan = 1'b1;
        do_start();
        repeat (3 * BIT_CLK) @(negedge clk);
        #1;
        check("t4_no_byte", {31'd0, bus.result_ready},  32'd0);
        check("t4_overrun", {31'd0, bus.overrun},       32'd0);
        check("t4_framing", {31'd0, bus.framing_error}, 32'd0);

        // 5: bad stop bit, line held low, then a good frame answers the pending request
        send_frame(8'h00, 1'b0);
        bus.inchan = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);
        #1;
        check("t5_framing_set", {31'd0, bus.framing_error}, 32'd1);
        check("t5_no_byte",     {31'd0, bus.result_ready},  32'd0);
        bus.inchan = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        push(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b1);
        wait_drain("t5_drain", 4 * BIT_CLK);

        // 6: reset (together with start) in the middle of bit 3 of 0xF0
        bus.inchan = 1'b0;
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_ready",   {31'd0, bus.result_ready},  32'd1);
        check("t6_result",  {24'd0, bus.result},        32'd0);
        check("t6_overrun", {31'd0, bus.overrun},       32'd0);
        check("t6_framing", {31'd0, bus.framing_error}, 32'd0);
        repeat (BIT_CLK / 2 - 2) @(negedge clk);
        bus.inchan = 1'b1;
        repeat (7 * BIT_CLK) @(negedge clk);
        push(8'h3C, 1'b0, 1'b0);
        do_start();
        send_frame(8'h3C, 1'b1);
        wait_drain("t6_drain", 4 * BIT_CLK);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
